// File: rtl/entropy_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : entropy_pkg                                                |
// | Purpose : Shared widths, sampler state type and helpers for the      |
// |           avalanche-noise entropy path.                              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package entropy_pkg;

  localparam int ENTROPY_WORD_W = 32;
  localparam int ENTROPY_DBG_W  = 8;
  localparam int ENTROPY_CNT_W  = $clog2(ENTROPY_WORD_W);

  typedef enum logic [0:0] {
    DISABLED = 1'b0,
    COLLECT  = 1'b1
  } sampler_state_t;

  // Width of a counter that must hold 0..min_gap, never narrower than 1 bit.
  function automatic int gap_width(input int min_gap);
    return (min_gap < 1) ? 1 : $clog2(min_gap + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/noise_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : noise_sync_edge                                            |
// | Purpose : Multi-flop synchroniser for an asynchronous noise pin,     |
// |           followed by a previous-value flop and rising-edge pulse.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module noise_sync_edge
  import entropy_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noise_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw pin through the synchroniser, then remember the last synchronised level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], noise_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/avalanche_noise_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : avalanche_noise_sampler                                    |
// | Purpose : Turns rising edges of the avalanche-noise pin into 32-bit  |
// |           entropy words (one toggle-phase bit per accepted edge)     |
// |           delivered over a valid/ack handshake.                      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module avalanche_noise_sampler
  import entropy_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_GAP     = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      noise,
  input  logic                      enable,
  output logic [ENTROPY_WORD_W-1:0] entropy_data,
  output logic                      entropy_valid,
  input  logic                      entropy_ack,
  output logic                      overrun,
  output logic [ENTROPY_DBG_W-1:0]  debug
);

  localparam int                      GAP_W    = gap_width(MIN_GAP);
  localparam logic [GAP_W-1:0]         GAP_MAX  = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0]         GAP_PRE  = GAP_MAX - GAP_W'(1);
  localparam logic [ENTROPY_CNT_W-1:0] LAST_BIT = ENTROPY_CNT_W'(ENTROPY_WORD_W - 1);

  logic                      noise_edge;
  logic                      gap_ok;
  logic                      accepted;

  logic                      flip_q;
  sampler_state_t            state_q,   state_d;
  logic [GAP_W-1:0]          gap_cnt_q, gap_cnt_d;
  logic [ENTROPY_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ENTROPY_WORD_W-1:0] shift_q,   shift_d;
  logic [ENTROPY_WORD_W-1:0] data_q,    data_d;
  logic                      valid_q,   valid_d;
  logic                      overrun_q, overrun_d;
  logic [ENTROPY_DBG_W-1:0]  dbg_q,     dbg_d;

  noise_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .noise_i (noise),
    .edge_o  (noise_edge)
  );

  // The counter is cleared on the accepting cycle, so an edge MIN_GAP cycles
  // later still sees MIN_GAP-1; either that or the saturated value passes.
  // With MIN_GAP=0 the counter sits at 0 == GAP_MAX and everything passes.
  assign gap_ok   = (gap_cnt_q == GAP_MAX) || (gap_cnt_q == GAP_PRE);
  assign accepted = noise_edge & enable & gap_ok;

  // Collection state simply follows the enable input.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DISABLED: if (enable)  state_d = COLLECT;
      COLLECT:  if (!enable) state_d = DISABLED;
      default:               state_d = DISABLED;
    endcase
  end

  // Gap counter: restart on an accepted edge, otherwise count up to saturation.
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (accepted) begin
      gap_cnt_d = '0;
    end else if (gap_cnt_q != GAP_MAX) begin
      gap_cnt_d = gap_cnt_q + GAP_W'(1);
    end
  end

  // Bit assembly, word hand-off, overrun tracking and delivery count.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    dbg_d     = dbg_q;

    if (valid_q && entropy_ack) begin
      valid_d = 1'b0;
    end

    if (state_d == DISABLED) begin
      bit_cnt_d = '0;
      shift_d   = '0;
      overrun_d = 1'b0;
    end else if (accepted) begin
      shift_d   = {shift_q[ENTROPY_WORD_W-2:0], flip_q};
      bit_cnt_d = bit_cnt_q + ENTROPY_CNT_W'(1);
      if (bit_cnt_q == LAST_BIT) begin
        // A pending word may be replaced only when it is being acked this cycle.
        if (!valid_q || entropy_ack) begin
          data_d  = shift_d;
          valid_d = 1'b1;
          dbg_d   = dbg_q + ENTROPY_DBG_W'(1);
        end else begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  // All sampler state registers; the toggle runs regardless of enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flip_q    <= 1'b0;
      state_q   <= DISABLED;
      gap_cnt_q <= GAP_MAX;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      dbg_q     <= '0;
    end else begin
      flip_q    <= ~flip_q;
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      dbg_q     <= dbg_d;
    end
  end

  assign entropy_data  = data_q;
  assign entropy_valid = valid_q;
  assign overrun       = overrun_q;
  assign debug         = dbg_q;

endmodule
`default_nettype wire
